pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage ARM pipeline. Drives the freeze and flush inputs
//  of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves RAW data
//  hazards (with or without forwarding), taken-branch flushes and multi-cycle SRAM waits.
//  Includes a wait-timeout watchdog and a stall-cycle counter.
// PARAMETERS
//  REG_ADDR_W  4   width of register-file addresses
//  MAX_WAIT    15  SRAM wait cycles tolerated before mem_timeout is raised (1..2^WAIT_W-1)
//  WAIT_W      4   width of the internal wait counter
//  CNT_W       16  width of stall_count
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           asynchronous, active-low reset
//  id_src1        in   REG_ADDR_W  ID-stage source register 1
//  id_src2        in   REG_ADDR_W  ID-stage source register 2
//  id_two_src     in   1           ID instruction reads id_src2
//  id_src_valid   in   1           ID instruction reads id_src1 (0 for branch/NOP)
//  ex_dest        in   REG_ADDR_W  EX-stage destination register
//  ex_wb_en       in   1           EX instruction writes back
//  ex_mem_read    in   1           EX instruction is a load
//  mem_dest       in   REG_ADDR_W  MEM-stage destination register
//  mem_wb_en      in   1           MEM instruction writes back
//  fwd_en         in   1           forwarding unit enabled
//  branch_taken   in   1           EX-stage branch resolved taken
//  mem_req        in   1           MEM stage issues an SRAM access
//  mem_ready      in   1           SRAM access completes this cycle
//  pc_freeze      out  1           hold PC
//  if_id_freeze   out  1           hold IF/ID register
//  if_id_flush    out  1           clear IF/ID register
//  id_ex_freeze   out  1           hold ID/EX register
//  id_ex_flush    out  1           clear ID/EX register (bubble)
//  ex_mem_freeze  out  1           hold EX/MEM register
//  mem_wb_freeze  out  1           hold MEM/WB register
//  mem_timeout    out  1           sticky: SRAM wait exceeded MAX_WAIT
//  stall_count    out  CNT_W       saturating count of cycles with pc_freeze=1
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, TIMEOUT. Reset -> RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
//  - All freeze/flush outputs are combinational from state+inputs; with idle inputs in RUN all are 0.
//  - mem_stall = (RUN & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready) | TIMEOUT.
//  - mem_stall=1: every freeze output =1, both flushes =0 (branch/hazard deferred, inputs held by
//    frozen registers, re-evaluated on release).
//  - RUN -> MEM_WAIT when mem_req & ~mem_ready; wait_cnt <= 1.
//  - MEM_WAIT: mem_ready=1 -> RUN same edge, freezes drop in that cycle (zero extra latency);
//    else wait_cnt++; wait_cnt==MAX_WAIT & ~mem_ready -> TIMEOUT.
//  - TIMEOUT: mem_timeout=1, pipeline frozen until reset; mem_ready ignored.
//  - hazard (no mem_stall): m1 = id_src_valid & (id_src1==X), m2 = id_two_src & (id_src2==X).
//    fwd_en=0: hazard = (m1|m2 for X=ex_dest & ex_wb_en) | (m1|m2 for X=mem_dest & mem_wb_en).
//    fwd_en=1: hazard = (m1|m2 for X=ex_dest) & ex_wb_en & ex_mem_read (load-use only).
//    hazard -> pc_freeze=if_id_freeze=1, id_ex_flush=1; single-cycle per evaluation.
//  - branch_taken (no mem_stall): if_id_flush=id_ex_flush=1, pc/if_id freeze=0; overrides hazard.
//  - Priority: TIMEOUT > mem_stall > branch_taken > hazard.
//  - stall_count increments each cycle pc_freeze=1, saturates at all-ones, no wrap.
//  - Reset asserted mid-wait: immediate return to RUN, counters cleared, outputs per idle inputs.
// STRUCTURE
//  - pipeline_ctrl_defs.vh: FSM state encodings (RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2), default widths.
//  - Sub-module hazard_detect_unit: combinational RAW compare producing hazard; FSM, wait counter,
//    stall counter and output priority mux stay in this module.
// TESTING
//  1 Reset: rst=0 with idle inputs -> all outputs 0, stall_count=0; release, 5 idle cycles -> unchanged.
//  2 fwd_en=1, ex_mem_read=1, ex_wb_en=1, ex_dest=3, id_src1=3 -> 1 cycle pc_freeze, if_id_freeze,
//    id_ex_flush; ex_dest=4 instead -> no stall.
//  3 fwd_en=0, mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 -> stall; id_two_src=0 -> none.
//  4 mem_req=1, mem_ready low 3 cycles then 1 -> all freezes high exactly 3 cycles, stall_count=3.
//  5 branch_taken=1 with simultaneous load-use hazard -> flushes only, pc_freeze=0; same during
//    mem wait -> flushes suppressed until mem_ready.
//  6 mem_req=1, mem_ready never -> mem_timeout=1 after MAX_WAIT+1 cycles, sticky until rst=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and default widths for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned DefRegAddrW = 4;
  localparam int unsigned DefMaxWait  = 15;
  localparam int unsigned DefWaitW    = 4;
  localparam int unsigned DefCntW     = 16;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StTimeout = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_ex_freeze;
    logic id_ex_flush;
    logic ex_mem_freeze;
    logic mem_wb_freeze;
  } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory status into the sequencer and freeze/flush controls back to the pipeline.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic                  id_src_valid;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_wb_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  fwd_en;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  pc_freeze;
  logic                  if_id_freeze;
  logic                  if_id_flush;
  logic                  id_ex_freeze;
  logic                  id_ex_flush;
  logic                  ex_mem_freeze;
  logic                  mem_wb_freeze;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_src1, id_src2, id_two_src, id_src_valid, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze,
           mem_wb_freeze, mem_timeout, stall_count
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_src_valid, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze,
           mem_wb_freeze, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_hazard.sv
// Combinational RAW hazard compare between the ID sources and EX/MEM destinations.
module pipeline_stall_ctrl_hazard #(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  fwd_en,
  output logic                  hazard
);
  logic ex_match;
  logic mem_match;

  always_comb begin
    ex_match  = (src_valid && (src1 == ex_dest))  || (two_src && (src2 == ex_dest));
    mem_match = (src_valid && (src1 == mem_dest)) || (two_src && (src2 == mem_dest));
    // With forwarding only a load in EX cannot be bypassed in time.
    if (fwd_en) begin
      hazard = ex_match && ex_wb_en && ex_mem_read;
    end else begin
      hazard = (ex_match && ex_wb_en) || (mem_match && mem_wb_en);
    end
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: SRAM wait FSM with watchdog, branch flush, RAW stall, stall counter.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DefRegAddrW,
  parameter int unsigned MAX_WAIT   = DefMaxWait,
  parameter int unsigned WAIT_W     = DefWaitW,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_stall_ctrl_if.slave bus
);
  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  count_q;
  logic              timeout_q;
  logic              hazard;
  logic              mem_stall;
  ctrl_t             ctrl;

  pipeline_stall_ctrl_hazard #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .src1       (bus.id_src1),
    .src2       (bus.id_src2),
    .two_src    (bus.id_two_src),
    .src_valid  (bus.id_src_valid),
    .ex_dest    (bus.ex_dest),
    .ex_wb_en   (bus.ex_wb_en),
    .ex_mem_read(bus.ex_mem_read),
    .mem_dest   (bus.mem_dest),
    .mem_wb_en  (bus.mem_wb_en),
    .fwd_en     (bus.fwd_en),
    .hazard     (hazard)
  );

  // Freeze the whole pipe the same cycle the SRAM is not ready; release as soon as it is.
  always_comb begin
    mem_stall = ((state_q == StRun) && bus.mem_req && !bus.mem_ready) ||
                ((state_q == StMemWait) && !bus.mem_ready) ||
                (state_q == StTimeout);
  end

  always_comb begin
    ctrl = '0;
    if (mem_stall) begin
      ctrl.pc_freeze     = 1'b1;
      ctrl.if_id_freeze  = 1'b1;
      ctrl.id_ex_freeze  = 1'b1;
      ctrl.ex_mem_freeze = 1'b1;
      ctrl.mem_wb_freeze = 1'b1;
    end else if (bus.branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (hazard) begin
      ctrl.pc_freeze    = 1'b1;
      ctrl.if_id_freeze = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    bus.pc_freeze     = ctrl.pc_freeze;
    bus.if_id_freeze  = ctrl.if_id_freeze;
    bus.if_id_flush   = ctrl.if_id_flush;
    bus.id_ex_freeze  = ctrl.id_ex_freeze;
    bus.id_ex_flush   = ctrl.id_ex_flush;
    bus.ex_mem_freeze = ctrl.ex_mem_freeze;
    bus.mem_wb_freeze = ctrl.mem_wb_freeze;
    bus.mem_timeout   = timeout_q;
    bus.stall_count   = count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.mem_req && !bus.mem_ready) begin
            state_q <= StMemWait;
            wait_q  <= WAIT_W'(1);
          end
        end
        StMemWait: begin
          if (bus.mem_ready) begin
            state_q <= StRun;
            wait_q  <= '0;
          end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
            state_q   <= StTimeout;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        StTimeout: timeout_q <= 1'b1;
        default:   state_q   <= StRun;
      endcase
      if (ctrl.pc_freeze && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end
endmodule
